alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequential arbiter that shares the single ALU between the manual (front-panel) requester and the CPU requester, replacing static mode-based selection with a request/acknowledge protocol. It grants one requester at a time, registers that requester's operands and opcode onto the ALU inputs, and issues a one-cycle start. It then waits for ALU completion, with a watchdog, and routes the result back to the owner. It sits between both requesters and the ALU, upstream of the result display and CPU writeback.

## Interface
- DATA_W, 8, operand width
- OP_W, 3, opcode width
- TIMEOUT, 15, maximum WAIT cycles before abort (≥1)
- STARVE_LIMIT, 4, consecutive priority-side grants allowed while the other side is requesting (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  arbitration priority: 0 = manual, 1 = CPU
- man_req, cpu_req  in  1  request; held high with operands stable until the matching ack
- man_a, man_b, cpu_a, cpu_b  in  DATA_W  operands
- man_op, cpu_op  in  OP_W  opcode
- man_ack, cpu_ack  out  1  one-cycle grant pulse; operands captured
- alu_a, alu_b  out  DATA_W  registered operands to the ALU
- alu_op  out  OP_W  registered opcode
- alu_start  out  1  one-cycle start pulse
- alu_done  in  1  ALU completion; sampled only in WAIT
- alu_result  in  2*DATA_W  ALU result (16-bit for MUL)
- result  out  2*DATA_W  registered result, held until the next RESP
- man_rsp_valid, cpu_rsp_valid  out  1  one-cycle response pulse to the owner
- timeout_err  out  1  high with rsp_valid when the op was aborted
- owner  out  1  0 = manual, 1 = CPU; valid while busy
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states and transitions:
  - IDLE: on any req, arbitrate, go to ISSUE.
  - ISSUE: go to WAIT.
  - WAIT: on alu_done or timeout, go to RESP.
  - RESP: go to IDLE.
- Arbitration happens in IDLE only:
  - A single requester wins.
  - If both request, the mode-selected side wins unless starve_cnt == STARVE_LIMIT; then the other side wins.
- starve_cnt (priority-side grants made while the other side is requesting):
  - increments on each such grant;
  - clears when the non-priority side is granted, or when a grant is made with no contention.
- mode is sampled only at arbitration. Changing it mid-operation does not affect the current owner.
- On grant, the following register on the same edge: alu_a/b/op from the winner, owner, and ack (pulse asserted during ISSUE).
- alu_start is high for exactly the ISSUE cycle.
- WAIT:
  - wait_cnt counts from 0.
  - If alu_done = 1, capture alu_result into result and set timeout_err = 0.
  - Otherwise, if wait_cnt == TIMEOUT−1, set result = 0 and timeout_err = 1.
- RESP: the rsp_valid of the owner only is high. timeout_err is valid in the same cycle and is 0 otherwise.
- alu_done outside WAIT is ignored. A late done after a timeout does not alter result.
- Requests seen in RESP are not granted until IDLE. A request dropped before its ack is never serviced.

## Timing
- Reset is asynchronous and immediate:
  - state = IDLE;
  - all outputs 0, including result, owner and alu_a/b/op;
  - starve_cnt = 0, wait_cnt = 0.
- Any in-flight op is discarded and no rsp_valid is issued for it.
- Cycle sequence for a request sampled at edge E0:
  - cycle E0–E1: ISSUE, with ack and alu_start;
  - WAIT from E1;
  - alu_done sampled high at edge Ek → RESP during Ek–Ek+1;
  - IDLE from Ek+1.
- Minimum occupancy is 4 cycles per op (ALU done in the first WAIT cycle).
- Next grant is earliest at the edge ending the first IDLE cycle.
- Timeout: RESP is entered at the edge ending the TIMEOUT-th WAIT cycle.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_ADD = 000, OP_SUB = 001, OP_MUL = 010, OP_DIV = 011, OP_EQ = 101, OP_GT = 110;
  - FSM state encodings;
  - owner encodings OWN_MAN = 0, OWN_CPU = 1.
- Natural sub-module: alu_arb_pick. It is combinational winner selection from (man_req, cpu_req, mode, starve_cnt), kept separate so it can be verified exhaustively.
- FSM, counters and registers live in the top.

## Test plan
- mode=0, man 10/5/ADD, ALU model asserts done with 15 in the first WAIT cycle → man_ack once; alu_a=10, alu_b=5, alu_op=000; alu_start 1 cycle; man_rsp_valid with result=15; cpu_rsp_valid stays 0; 4 cycles total.
- mode=1, both request simultaneously (cpu 40/8/DIV, man 99/88/111) → CPU granted first, result 5. Manual is then granted in the following IDLE with alu_a=99.
- mode=0, both requesting continuously, STARVE_LIMIT=4 → grant order M,M,M,M,C,M,M,M,M,C.
- alu_done never asserted → exactly 15 WAIT cycles, then rsp_valid to the owner with result=0 and timeout_err=1. A later stray alu_done leaves result=0.
- rst pulsed mid-WAIT → busy, owner, alu_a/b/op and result are 0 immediately, and no rsp_valid is issued. Next cpu 60/30/GT completes normally.
- Mode toggled 0→1 during a manual op's WAIT → manual op completes to man_rsp_valid. With both then pending, CPU wins the next arbitration.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, arbiter state encoding and owner encoding
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b101;
  localparam logic [2:0] OP_GT  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Owner encoding doubles as the mode encoding: mode selects the side that owns priority.
  localparam logic OWN_MAN = 1'b0;
  localparam logic OWN_CPU = 1'b1;

endpackage

// File: rtl/alu_arb_pick.sv
// rtl/alu_arb_pick.sv - combinational winner selection between manual and CPU requesters
module alu_arb_pick
  import alu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             man_req,
  input  logic             cpu_req,
  input  logic             mode,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant,
  output logic             winner,
  output logic             prio_win
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic contended;

  assign contended = man_req & cpu_req;
  assign grant     = man_req | cpu_req;

  // prio_win marks a priority-side grant made against a waiting opponent.
  always_comb begin
    winner   = OWN_MAN;
    prio_win = 1'b0;
    if (contended) begin
      if (starve_cnt == LIMIT) begin
        winner = ~mode;
      end else begin
        winner   = mode;
        prio_win = 1'b1;
      end
    end else if (cpu_req) begin
      winner = OWN_CPU;
    end else begin
      winner = OWN_MAN;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - request/ack arbiter sharing one ALU between manual and CPU requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int OP_W         = 3,
  parameter int TIMEOUT      = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                man_req,
  input  logic                cpu_req,
  input  logic [DATA_W-1:0]   man_a,
  input  logic [DATA_W-1:0]   man_b,
  input  logic [DATA_W-1:0]   cpu_a,
  input  logic [DATA_W-1:0]   cpu_b,
  input  logic [OP_W-1:0]     man_op,
  input  logic [OP_W-1:0]     cpu_op,
  output logic                man_ack,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic [2*DATA_W-1:0] result,
  output logic                man_rsp_valid,
  output logic                cpu_rsp_valid,
  output logic                timeout_err,
  output logic                owner,
  output logic                busy
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

  arb_state_t      state;
  logic [SC_W-1:0] starve_cnt;
  logic [WC_W-1:0] wait_cnt;
  logic            grant;
  logic            winner;
  logic            prio_win;

  alu_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (SC_W)
  ) u_pick (
    .man_req    (man_req),
    .cpu_req    (cpu_req),
    .mode       (mode),
    .starve_cnt (starve_cnt),
    .grant      (grant),
    .winner     (winner),
    .prio_win   (prio_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      starve_cnt    <= '0;
      wait_cnt      <= '0;
      man_ack       <= 1'b0;
      cpu_ack       <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      alu_start     <= 1'b0;
      result        <= '0;
      man_rsp_valid <= 1'b0;
      cpu_rsp_valid <= 1'b0;
      timeout_err   <= 1'b0;
      owner         <= OWN_MAN;
      busy          <= 1'b0;
    end else begin
      man_ack       <= 1'b0;
      cpu_ack       <= 1'b0;
      alu_start     <= 1'b0;
      man_rsp_valid <= 1'b0;
      cpu_rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state      <= ST_ISSUE;
            busy       <= 1'b1;
            owner      <= winner;
            alu_start  <= 1'b1;
            starve_cnt <= prio_win ? starve_cnt + 1'b1 : '0;
            if (winner == OWN_CPU) begin
              alu_a   <= cpu_a;
              alu_b   <= cpu_b;
              alu_op  <= cpu_op;
              cpu_ack <= 1'b1;
            end else begin
              alu_a   <= man_a;
              alu_b   <= man_b;
              alu_op  <= man_op;
              man_ack <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          // A genuine completion wins over the watchdog on the last WAIT cycle.
          if (alu_done || wait_cnt == WAIT_LAST) begin
            state       <= ST_RESP;
            result      <= alu_done ? alu_result : '0;
            timeout_err <= ~alu_done;
            if (owner == OWN_CPU) begin
              cpu_rsp_valid <= 1'b1;
            end else begin
              man_rsp_valid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          timeout_err <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural arbitration model
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DATA_W       = 8;
  localparam int OP_W         = 3;
  localparam int TIMEOUT      = 15;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mode = 1'b0;
  logic              man_req = 1'b0;
  logic              cpu_req = 1'b0;
  logic [DATA_W-1:0] man_a = '0, man_b = '0, cpu_a = '0, cpu_b = '0;
  logic [OP_W-1:0]   man_op = '0, cpu_op = '0;
  logic              alu_done = 1'b0;
  logic [15:0]       alu_result = '0;
  logic              man_ack, cpu_ack, alu_start;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [15:0]       result;
  logic              man_rsp_valid, cpu_rsp_valid, timeout_err, owner, busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(
    .DATA_W (DATA_W), .OP_W (OP_W), .TIMEOUT (TIMEOUT), .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk), .rst (rst), .mode (mode),
    .man_req (man_req), .cpu_req (cpu_req),
    .man_a (man_a), .man_b (man_b), .cpu_a (cpu_a), .cpu_b (cpu_b),
    .man_op (man_op), .cpu_op (cpu_op),
    .man_ack (man_ack), .cpu_ack (cpu_ack),
    .alu_a (alu_a), .alu_b (alu_b), .alu_op (alu_op), .alu_start (alu_start),
    .alu_done (alu_done), .alu_result (alu_result), .result (result),
    .man_rsp_valid (man_rsp_valid), .cpu_rsp_valid (cpu_rsp_valid),
    .timeout_err (timeout_err), .owner (owner), .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      OP_ADD:  return 16'(a) + 16'(b);
      OP_SUB:  return 16'(a) - 16'(b);
      OP_MUL:  return 16'(a) * 16'(b);
      OP_DIV:  return (b == 8'd0) ? 16'h0 : 16'(a / b);
      OP_EQ:   return {15'd0, a == b};
      OP_GT:   return {15'd0, a > b};
      default: return 16'h0;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    man_req = 1'b0; cpu_req = 1'b0; alu_done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ack(output int who, output int cyc);
    who = -1; cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (man_ack || cpu_ack) begin
        who = cpu_ack ? 1 : 0;
        cyc = i;
        return;
      end
    end
  endtask

  // Raises alu_done in WAIT cycle d+1 (counted from the first sample after the call).
  task automatic drive_done(input int d, input logic [15:0] res, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (man_rsp_valid || cpu_rsp_valid) begin
        alu_done = 1'b0;
        cyc = i;
        return;
      end
      alu_done   = (i == d + 1);
      alu_result = alu_done ? res : 16'($urandom);
    end
    alu_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    n_cmp++; if ({man_ack, cpu_ack, alu_start} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %0h expected 0", {man_ack, cpu_ack, alu_start}); end
    n_cmp++; if ({alu_a, alu_b, alu_op, owner} !== '0) begin n_bad++; $display("FAIL reset_alu_regs: got %0h expected 0", {alu_a, alu_b, alu_op, owner}); end
    n_cmp++; if ({result, man_rsp_valid, cpu_rsp_valid, timeout_err} !== '0) begin n_bad++; $display("FAIL reset_resp: got %0h expected 0", {result, man_rsp_valid, cpu_rsp_valid, timeout_err}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    mode = 1'b0; cpu_req = 1'b0;
    man_req = 1'b1; man_a = 8'd10; man_b = 8'd5; man_op = OP_ADD;
    step();
    n_cmp++; if ({man_ack, cpu_ack} !== 2'b10) begin n_bad++; $display("FAIL basic_ack: got %0b expected 10", {man_ack, cpu_ack}); end
    n_cmp++; if (alu_start !== 1'b1) begin n_bad++; $display("FAIL basic_start: got %0h expected 1", alu_start); end
    n_cmp++; if ({alu_a, alu_b, alu_op} !== {8'd10, 8'd5, OP_ADD}) begin n_bad++; $display("FAIL basic_operands: got %0h expected %0h", {alu_a, alu_b, alu_op}, {8'd10, 8'd5, OP_ADD}); end
    n_cmp++; if ({busy, owner} !== 2'b10) begin n_bad++; $display("FAIL basic_owner: got %0b expected 10", {busy, owner}); end
    man_req = 1'b0;
    step();
    n_cmp++; if ({man_ack, alu_start} !== 2'b00) begin n_bad++; $display("FAIL basic_pulse_width: got %0b expected 00", {man_ack, alu_start}); end
    alu_done = 1'b1; alu_result = alu_model(8'd10, 8'd5, OP_ADD);
    step();
    alu_done = 1'b0;
    n_cmp++; if ({man_rsp_valid, cpu_rsp_valid, timeout_err} !== 3'b100) begin n_bad++; $display("FAIL basic_rsp: got %0b expected 100", {man_rsp_valid, cpu_rsp_valid, timeout_err}); end
    n_cmp++; if (result !== 16'd15) begin n_bad++; $display("FAIL basic_result: got %0d expected 15", result); end
    step();
    n_cmp++; if ({busy, man_rsp_valid, man_ack} !== 3'b000) begin n_bad++; $display("FAIL basic_idle: got %0b expected 000", {busy, man_rsp_valid, man_ack}); end
  endtask

  task automatic test_priority();
    int who, cyc;
    mode = 1'b1;
    cpu_req = 1'b1; cpu_a = 8'd40; cpu_b = 8'd8;  cpu_op = OP_DIV;
    man_req = 1'b1; man_a = 8'd99; man_b = 8'd88; man_op = 3'b111;
    wait_ack(who, cyc);
    n_cmp++; if (who !== 1 || cyc !== 1) begin n_bad++; $display("FAIL prio_cpu_first: got who=%0d cyc=%0d expected who=1 cyc=1", who, cyc); end
    n_cmp++; if ({alu_a, alu_b, alu_op} !== {8'd40, 8'd8, OP_DIV}) begin n_bad++; $display("FAIL prio_cpu_operands: got %0h expected %0h", {alu_a, alu_b, alu_op}, {8'd40, 8'd8, OP_DIV}); end
    cpu_req = 1'b0;
    drive_done(0, alu_model(8'd40, 8'd8, OP_DIV), cyc);
    n_cmp++; if ({cpu_rsp_valid, man_rsp_valid} !== 2'b10 || result !== 16'd5 || cyc !== 2) begin n_bad++; $display("FAIL prio_cpu_rsp: got rsp=%0b result=%0d cyc=%0d expected rsp=10 result=5 cyc=2", {cpu_rsp_valid, man_rsp_valid}, result, cyc); end
    wait_ack(who, cyc);
    n_cmp++; if (who !== 0 || cyc !== 2 || alu_a !== 8'd99) begin n_bad++; $display("FAIL prio_man_next: got who=%0d cyc=%0d alu_a=%0d expected who=0 cyc=2 alu_a=99", who, cyc, alu_a); end
    man_req = 1'b0;
    drive_done(1, alu_model(8'd99, 8'd88, 3'b111), cyc);
    n_cmp++; if (man_rsp_valid !== 1'b1 || cyc !== 3) begin n_bad++; $display("FAIL prio_man_rsp: got rsp=%0b cyc=%0d expected rsp=1 cyc=3", man_rsp_valid, cyc); end
    step();
  endtask

  task automatic test_timeout();
    int who, cyc;
    mode = 1'b0;
    cpu_req = 1'b1; cpu_a = 8'd12; cpu_b = 8'd11; cpu_op = OP_MUL;
    wait_ack(who, cyc);
    cpu_req = 1'b0;
    drive_done(0, alu_model(8'd12, 8'd11, OP_MUL), cyc);
    n_cmp++; if (result !== 16'd132 || cpu_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL mul_result: got %0d rsp=%0b expected 132 rsp=1", result, cpu_rsp_valid); end
    man_req = 1'b1; man_a = 8'd3; man_b = 8'd4; man_op = OP_SUB;
    wait_ack(who, cyc);
    n_cmp++; if (who !== 0) begin n_bad++; $display("FAIL to_grant: got who=%0d expected 0", who); end
    man_req = 1'b0;
    drive_done(1000, 16'h0, cyc);
    n_cmp++; if (cyc !== TIMEOUT + 1) begin n_bad++; $display("FAIL to_wait_cycles: got %0d expected %0d", cyc - 1, TIMEOUT); end
    n_cmp++; if ({man_rsp_valid, cpu_rsp_valid, timeout_err} !== 3'b101 || result !== 16'd0) begin n_bad++; $display("FAIL to_rsp: got rsp/err=%0b result=%0h expected 101 result=0", {man_rsp_valid, cpu_rsp_valid, timeout_err}, result); end
    step();
    n_cmp++; if ({timeout_err, man_rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL to_err_clear: got %0b expected 00", {timeout_err, man_rsp_valid}); end
    alu_done = 1'b1; alu_result = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (result !== 16'd0 || {man_rsp_valid, cpu_rsp_valid, busy} !== 3'b000) begin n_bad++; $display("FAIL to_late_done: got result=%0h flags=%0b expected 0 000", result, {man_rsp_valid, cpu_rsp_valid, busy}); end
    end
    alu_done = 1'b0;
  endtask

  task automatic test_starvation();
    int who, cyc;
    int exp_seq [10];
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset();
    mode = 1'b0;
    man_req = 1'b1; man_a = 8'd1; man_b = 8'd2; man_op = OP_ADD;
    cpu_req = 1'b1; cpu_a = 8'd7; cpu_b = 8'd3; cpu_op = OP_SUB;
    for (int k = 0; k < 10; k++) begin
      wait_ack(who, cyc);
      n_cmp++; if (who !== exp_seq[k] || cyc !== (k == 0 ? 1 : 2)) begin n_bad++; $display("FAIL starve_grant_%0d: got who=%0d cyc=%0d expected who=%0d cyc=%0d", k, who, cyc, exp_seq[k], (k == 0 ? 1 : 2)); end
      if (k == 9) begin man_req = 1'b0; cpu_req = 1'b0; end
      drive_done(0, 16'(k + 1), cyc);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    int who, cyc;
    mode = 1'b0;
    cpu_req = 1'b1; cpu_a = 8'd77; cpu_b = 8'd3; cpu_op = OP_ADD;
    wait_ack(who, cyc);
    cpu_req = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({busy, owner} !== 2'b00) begin n_bad++; $display("FAIL rst_busy_owner: got %0b expected 00", {busy, owner}); end
    n_cmp++; if ({alu_a, alu_b, alu_op} !== '0 || result !== 16'd0) begin n_bad++; $display("FAIL rst_regs: got alu=%0h result=%0h expected 0 0", {alu_a, alu_b, alu_op}, result); end
    step();
    rst = 1'b0;
    alu_done = 1'b1; alu_result = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({man_rsp_valid, cpu_rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_no_rsp: got %0b expected 00", {man_rsp_valid, cpu_rsp_valid}); end
    end
    alu_done = 1'b0;
    cpu_req = 1'b1; cpu_a = 8'd60; cpu_b = 8'd30; cpu_op = OP_GT;
    wait_ack(who, cyc);
    n_cmp++; if (who !== 1 || cyc !== 1) begin n_bad++; $display("FAIL rst_next_grant: got who=%0d cyc=%0d expected 1 1", who, cyc); end
    cpu_req = 1'b0;
    drive_done(2, alu_model(8'd60, 8'd30, OP_GT), cyc);
    n_cmp++; if (cpu_rsp_valid !== 1'b1 || result !== 16'd1 || timeout_err !== 1'b0 || cyc !== 4) begin n_bad++; $display("FAIL rst_next_rsp: got rsp=%0b result=%0d err=%0b cyc=%0d expected 1 1 0 4", cpu_rsp_valid, result, timeout_err, cyc); end
    step();
  endtask

  task automatic test_mode_toggle();
    int who, cyc;
    mode = 1'b0;
    man_req = 1'b1; man_a = 8'd20; man_b = 8'd7; man_op = OP_SUB;
    wait_ack(who, cyc);
    man_req = 1'b0;
    step();
    mode = 1'b1;
    cpu_req = 1'b1; cpu_a = 8'd9; cpu_b = 8'd9; cpu_op = OP_EQ;
    man_req = 1'b1; man_a = 8'd1; man_b = 8'd2; man_op = OP_ADD;
    drive_done(1, alu_model(8'd20, 8'd7, OP_SUB), cyc);
    n_cmp++; if ({man_rsp_valid, cpu_rsp_valid} !== 2'b10 || result !== 16'd13 || owner !== 1'b0) begin n_bad++; $display("FAIL toggle_man_rsp: got rsp=%0b result=%0d owner=%0b expected 10 13 0", {man_rsp_valid, cpu_rsp_valid}, result, owner); end
    wait_ack(who, cyc);
    n_cmp++; if (who !== 1) begin n_bad++; $display("FAIL toggle_cpu_wins: got who=%0d expected 1", who); end
    cpu_req = 1'b0;
    drive_done(0, alu_model(8'd9, 8'd9, OP_EQ), cyc);
    wait_ack(who, cyc);
    n_cmp++; if (who !== 0 || alu_a !== 8'd1) begin n_bad++; $display("FAIL toggle_man_after: got who=%0d alu_a=%0d expected 0 1", who, alu_a); end
    man_req = 1'b0;
    drive_done(0, 16'd3, cyc);
    step();
  endtask

  task automatic test_random();
    bit   man_pend = 0, cpu_pend = 0, in_op = 0, exp_grant = 0, idle_flag, rsp_exp, win, drained = 0;
    int   starve = 0, d = 0, wait_i = 0, rsp_at;
    logic exp_own = 0, exp_to = 0;
    logic [15:0] exp_res = '0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      n_cmp++; if ((man_ack | cpu_ack) !== exp_grant || (man_ack & cpu_ack)) begin n_bad++; $display("FAIL rand_grant_c%0d: got ack=%0b expected grant=%0b", cyc, {man_ack, cpu_ack}, exp_grant); end
      if (man_ack || cpu_ack) begin
        if (man_pend && cpu_pend) begin
          if (starve == STARVE_LIMIT) begin win = ~mode; starve = 0; end
          else begin win = mode; starve++; end
        end else begin
          win = cpu_pend;
          starve = 0;
        end
        n_cmp++; if (cpu_ack !== win) begin n_bad++; $display("FAIL rand_winner_c%0d: got cpu_ack=%0b expected %0b", cyc, cpu_ack, win); end
        if (win) begin
          n_cmp++; if ({alu_a, alu_b, alu_op, alu_start} !== {cpu_a, cpu_b, cpu_op, 1'b1}) begin n_bad++; $display("FAIL rand_cpu_ops_c%0d: got %0h expected %0h", cyc, {alu_a, alu_b, alu_op, alu_start}, {cpu_a, cpu_b, cpu_op, 1'b1}); end
          exp_res = alu_model(cpu_a, cpu_b, cpu_op);
          cpu_pend = 0;
        end else begin
          n_cmp++; if ({alu_a, alu_b, alu_op, alu_start} !== {man_a, man_b, man_op, 1'b1}) begin n_bad++; $display("FAIL rand_man_ops_c%0d: got %0h expected %0h", cyc, {alu_a, alu_b, alu_op, alu_start}, {man_a, man_b, man_op, 1'b1}); end
          exp_res = alu_model(man_a, man_b, man_op);
          man_pend = 0;
        end
        exp_own = win;
        in_op = 1; wait_i = 0;
        d = $urandom_range(0, TIMEOUT + 2);
        exp_to = (d >= TIMEOUT);
      end else if (in_op) begin
        wait_i++;
      end
      rsp_at  = (d < TIMEOUT ? d : TIMEOUT - 1) + 2;
      rsp_exp = in_op && (wait_i == rsp_at);
      n_cmp++; if ({man_rsp_valid, cpu_rsp_valid} !== {rsp_exp && !exp_own, rsp_exp && exp_own}) begin n_bad++; $display("FAIL rand_rsp_c%0d: got %0b expected %0b", cyc, {man_rsp_valid, cpu_rsp_valid}, {rsp_exp && !exp_own, rsp_exp && exp_own}); end
      if (rsp_exp) begin
        n_cmp++; if (result !== (exp_to ? 16'h0 : exp_res) || timeout_err !== exp_to) begin n_bad++; $display("FAIL rand_result_c%0d: got %0h err=%0b expected %0h err=%0b", cyc, result, timeout_err, (exp_to ? 16'h0 : exp_res), exp_to); end
      end
      n_cmp++; if (busy !== in_op) begin n_bad++; $display("FAIL rand_busy_c%0d: got %0b expected %0b", cyc, busy, in_op); end
      idle_flag = !in_op;
      if (rsp_exp) in_op = 0;
      if (in_op && wait_i >= 1) alu_done = (wait_i == d + 1);
      else alu_done = ($urandom_range(0, 3) == 0);
      alu_result = (in_op && alu_done) ? exp_res : 16'($urandom);
      if (cyc < 2000) begin
        if (!man_pend && $urandom_range(0, 3) == 0) begin
          man_pend = 1; man_a = 8'($urandom); man_b = 8'($urandom); man_op = 3'($urandom);
        end
        if (!cpu_pend && $urandom_range(0, 3) == 0) begin
          cpu_pend = 1; cpu_a = 8'($urandom); cpu_b = 8'($urandom); cpu_op = 3'($urandom);
        end
        if ($urandom_range(0, 15) == 0) mode = ~mode;
      end else if (!man_pend && !cpu_pend && !in_op) begin
        drained = 1;
        break;
      end
      man_req = man_pend;
      cpu_req = cpu_pend;
      exp_grant = idle_flag && (man_req || cpu_req);
    end
    alu_done = 1'b0;
    n_cmp++; if (!drained) begin n_bad++; $display("FAIL rand_drain: got pending=%0b%0b in_op=%0b expected all clear", man_pend, cpu_pend, in_op); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_timeout();
    test_starvation();
    test_reset_mid_wait();
    test_mode_toggle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
